// File: rtl/nmcu_pkg.sv
// Shared types and sizes for the NMCU memory path: request/response structs
// and the cache arbiter state encoding.
package nmcu_pkg;

    localparam int ADDR_WIDTH   = 32;
    localparam int DATA_WIDTH   = 32;
    localparam int LEN_WIDTH    = 8;
    localparam int MAX_REQ      = 8;
    localparam int REQ_ID_WIDTH = $clog2(MAX_REQ);

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic                  write_en;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] rdata;
    } mem_resp_t;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ISSUE     = 2'd1,
        ARB_WAIT_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/nmcu_cache_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: searches from last_grant+1 (mod NUM_REQ)
// and returns the first active requester as one-hot, index and an any flag.
module rr_priority_picker
    import nmcu_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [REQ_ID_WIDTH-1:0] last_grant_i,
    output logic [NUM_REQ-1:0]      gnt_o,
    output logic [REQ_ID_WIDTH-1:0] idx_o,
    output logic                    any_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    int          cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        gnt_o    = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand     = (int'(last_grant_i) + off) % NUM_REQ;
            cand_idx = IW'(cand);
            if (!any_o && req_i[cand_idx]) begin
                gnt_o[cand_idx] = 1'b1;
                idx_o           = REQ_ID_WIDTH'(cand);
                any_o           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nmcu_cache_arbiter.sv
// Single-outstanding arbiter between NMCU requesters and the cache: one
// round-robin grant in IDLE, a one-cycle issue, then wait for data or timeout.
module nmcu_cache_arbiter
    import nmcu_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int DATA_WIDTH     = nmcu_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  mem_req_t                   req_i [NUM_REQ],
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [NUM_REQ-1:0]         resp_valid_o,
    output logic [DATA_WIDTH-1:0]      resp_rdata_o,
    output logic                       resp_err_o,
    output mem_req_t                   cache_req_o,
    input  mem_resp_t                  cache_resp_i,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o
);

    localparam int GW    = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t              state_q, state_d;
    logic [REQ_ID_WIDTH-1:0] last_q, last_d;
    logic [REQ_ID_WIDTH-1:0] owner_q, owner_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    mem_req_t                req_q, req_d;

    logic [NUM_REQ-1:0]      pick_gnt;
    logic [REQ_ID_WIDTH-1:0] pick_idx;
    logic                    pick_any;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i        (req_valid_i),
        .last_grant_i (last_q),
        .gnt_o        (pick_gnt),
        .idx_o        (pick_idx),
        .any_o        (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        req_ready_o  = '0;
        resp_valid_o = '0;
        resp_rdata_o = '0;
        resp_err_o   = 1'b0;
        cache_req_o  = '0;
        busy_o       = (state_q != ARB_IDLE);

        // While reset is held nothing may be accepted or completed.
        if (!rst) begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        req_ready_o = pick_gnt;
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (pick_gnt[i]) req_d = req_i[i];
                        end
                        owner_d = pick_idx;
                        last_d  = pick_idx;
                        state_d = ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    cache_req_o       = req_q;
                    cache_req_o.valid = 1'b1;
                    if (req_q.write_en) begin
                        resp_valid_o = NUM_REQ'(1) << owner_q;
                        state_d      = ARB_IDLE;
                    end else if (cache_resp_i.valid) begin
                        resp_valid_o = NUM_REQ'(1) << owner_q;
                        resp_rdata_o = cache_resp_i.rdata;
                        state_d      = ARB_IDLE;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = ARB_WAIT_RESP;
                    end
                end
                ARB_WAIT_RESP: begin
                    if (cache_resp_i.valid) begin
                        resp_valid_o = NUM_REQ'(1) << owner_q;
                        resp_rdata_o = cache_resp_i.rdata;
                        state_d      = ARB_IDLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                        resp_valid_o = NUM_REQ'(1) << owner_q;
                        resp_err_o   = 1'b1;
                        state_d      = ARB_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            last_q  <= REQ_ID_WIDTH'(NUM_REQ - 1);
            owner_q <= '0;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    assign grant_id_o = owner_q[GW-1:0];

endmodule

// File: tb/tb_nmcu_cache_arbiter.sv
// Directed bench for nmcu_cache_arbiter: write, read latency, round-robin
// order, timeout, zero-latency read and reset abandonment.
module tb_nmcu_cache_arbiter;
    import nmcu_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int TMO     = 8;

    logic               clk;
    logic               rst;
    logic [NUM_REQ-1:0] req_valid;
    mem_req_t           req [NUM_REQ];
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic               resp_err;
    mem_req_t           cache_req;
    mem_resp_t          cache_resp;
    logic               busy;
    logic [1:0]         grant_id;

    int total = 0;
    int bad   = 0;

    nmcu_cache_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_WIDTH     (DATA_WIDTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_i        (req),
        .req_ready_o  (req_ready),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .cache_req_o  (cache_req),
        .cache_resp_i (cache_resp),
        .busy_o       (busy),
        .grant_id_o   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 ns after the edge, checks 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd);
        req[i] = '{valid: 1'b0, addr: addr, len: 8'd1, write_en: we, wdata: wd};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_oh;
        rst        = 1'b1;
        req_valid  = '0;
        cache_resp = '0;
        for (int i = 0; i < NUM_REQ; i++) req[i] = '0;
        tick();
        tick();
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_resp", resp_valid, 0);
        check("rst_cache_req", cache_req, 0);
        check("rst_gid", grant_id, 0);
        rst = 1'b0;

        // Single write from requester 0
        tick();
        set_req(0, 1'b1, 32'h10, 32'hAB);
        req_valid = 3'b001;
        #1;
        check("wr_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        #1;
        check("wr_cache_valid", cache_req.valid, 1);
        check("wr_cache_we", cache_req.write_en, 1);
        check("wr_cache_addr", cache_req.addr, 32'h10);
        check("wr_cache_wdata", cache_req.wdata, 32'hAB);
        check("wr_resp", resp_valid, 3'b001);
        check("wr_rdata", resp_rdata, 0);
        check("wr_ready_issue", req_ready, 0);
        tick();
        #1;
        check("wr_idle", busy, 0);

        // Read from requester 1, cache answers 3 cycles after issue
        set_req(1, 1'b0, 32'h20, 32'h0);
        req_valid = 3'b010;
        #1;
        check("rd_ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        #1;
        check("rd_issue_valid", cache_req.valid, 1);
        check("rd_issue_we", cache_req.write_en, 0);
        check("rd_issue_addr", cache_req.addr, 32'h20);
        check("rd_issue_resp", resp_valid, 0);
        tick();
        #1;
        check("rd_wait_cache_req", cache_req, 0);
        check("rd_wait1_resp", resp_valid, 0);
        check("rd_wait1_busy", busy, 1);
        tick();
        #1;
        check("rd_wait2_resp", resp_valid, 0);
        tick();
        cache_resp = '{valid: 1'b1, rdata: 32'h55};
        #1;
        check("rd_resp", resp_valid, 3'b010);
        check("rd_rdata", resp_rdata, 32'h55);
        check("rd_err", resp_err, 0);
        check("rd_gid", grant_id, 1);
        tick();
        #1;
        check("rd_idle_ignore_resp", resp_valid, 0);
        check("rd_idle_busy", busy, 0);
        cache_resp = '0;

        // Round-robin with all three requesting continuously (writes)
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 32'h100 + i, 32'h0);
        req_valid = 3'b111;
        for (int n = 0; n < 6; n++) begin
            exp_oh = 3'b001 << (n % 3);
            #1;
            check($sformatf("rr_ready_%0d", n), req_ready, exp_oh);
            check($sformatf("rr_idle_%0d", n), busy, 0);
            tick();
            #1;
            check($sformatf("rr_resp_%0d", n), resp_valid, exp_oh);
            check($sformatf("rr_gid_%0d", n), grant_id, n % 3);
            check($sformatf("rr_noready_%0d", n), req_ready, 0);
            tick();
        end
        req_valid = '0;
        tick();

        // Read timeout on requester 2
        set_req(2, 1'b0, 32'h30, 32'h0);
        req_valid = 3'b100;
        #1;
        check("to_ready", req_ready, 3'b100);
        tick();
        req_valid = '0;
        for (int k = 1; k <= TMO; k++) begin
            tick();
            #1;
            if (k < TMO) begin
                check($sformatf("to_wait_%0d", k), resp_valid, 0);
            end else begin
                check("to_resp", resp_valid, 3'b100);
                check("to_err", resp_err, 1);
                check("to_rdata", resp_rdata, 0);
            end
        end
        tick();
        #1;
        check("to_idle", busy, 0);
        set_req(0, 1'b1, 32'h40, 32'h1);
        req_valid = 3'b001;
        #1;
        check("to_next_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        #1;
        check("to_next_resp", resp_valid, 3'b001);
        check("to_next_err", resp_err, 0);
        tick();

        // Response arriving on the timeout cycle wins
        set_req(1, 1'b0, 32'h50, 32'h0);
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        for (int k = 1; k < TMO; k++) tick();
        tick();
        cache_resp = '{valid: 1'b1, rdata: 32'hC3};
        #1;
        check("tie_resp", resp_valid, 3'b010);
        check("tie_err", resp_err, 0);
        check("tie_rdata", resp_rdata, 32'hC3);
        tick();
        cache_resp = '0;

        // Zero-latency read
        set_req(1, 1'b0, 32'h60, 32'h0);
        req_valid = 3'b010;
        #1;
        check("zl_ready", req_ready, 3'b010);
        tick();
        req_valid  = '0;
        cache_resp = '{valid: 1'b1, rdata: 32'h77};
        #1;
        check("zl_resp", resp_valid, 3'b010);
        check("zl_rdata", resp_rdata, 32'h77);
        check("zl_err", resp_err, 0);
        tick();
        cache_resp = '0;
        #1;
        check("zl_no_wait", busy, 0);

        // Reset during WAIT_RESP, then a late response
        set_req(2, 1'b0, 32'h70, 32'h0);
        req_valid = 3'b100;
        tick();
        req_valid = '0;
        tick();
        tick();
        #1;
        check("rw_in_wait", busy, 1);
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        cache_resp = '{valid: 1'b1, rdata: 32'h99};
        #1;
        check("rw_no_resp", resp_valid, 0);
        check("rw_idle", busy, 0);
        tick();
        cache_resp = '0;
        #1;
        check("rw_still_idle", busy, 0);
        check("rw_no_resp2", resp_valid, 0);
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 32'h200, 32'h0);
        req_valid = 3'b111;
        #1;
        check("rw_first_grant", req_ready, 3'b001);
        tick();
        req_valid = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
